// File: rtl/lsu_pkg.sv
// Shared types for the LSU request tracker: memory op encoding, op helpers and tracker entry.
package lsu_pkg;

  typedef enum logic [2:0] {
    LD_B  = 3'd0,
    LD_H  = 3'd1,
    LD_W  = 3'd2,
    LD_BU = 3'd3,
    LD_HU = 3'd4,
    ST_B  = 3'd5,
    ST_H  = 3'd6,
    ST_W  = 3'd7
  } mem_op_e;

  typedef struct packed {
    mem_op_e    op;
    logic [1:0] lo2;
    logic       kill;
  } trk_entry_t;

  function automatic logic is_store(input mem_op_e op);
    return op inside {ST_B, ST_H, ST_W};
  endfunction

  function automatic logic is_load(input mem_op_e op);
    return !is_store(op);
  endfunction

  function automatic logic [1:0] op_size(input mem_op_e op);
    case (op)
      LD_W, ST_W:        return 2'd2;
      LD_H, LD_HU, ST_H: return 2'd1;
      default:           return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_outst_fifo.sv
// In-order FIFO of in-flight LSU requests; kill_all marks every held entry as stale.
module lsu_outst_fifo
  import lsu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  trk_entry_t       push_data,
  input  logic             pop,
  input  logic             kill_all,
  output trk_entry_t       head,
  output logic [CNT_W-1:0] cnt,
  output logic             empty
);

  trk_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign head  = mem[rd_ptr];
  assign empty = (cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (kill_all)
        for (int i = 0; i < DEPTH; i++) mem[i].kill <= 1'b1;
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/lsu_req_tracker.sv
// EXE->MEM load/store issuer on the SRAM-like bus with N-deep in-order response tracking.
// Define LSU_ALE_CHECK_EN to enable the misalignment (ALE) check.
module lsu_req_tracker
  import lsu_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MAX_OUTST = 2,
  localparam int CNT_W    = $clog2(MAX_OUTST) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_wdata,
  output logic              ale_exc,
  input  logic              flush,
  output logic              data_sram_req,
  output logic              data_sram_wr,
  output logic [1:0]        data_sram_size,
  output logic [3:0]        data_sram_wstrb,
  output logic [ADDR_W-1:0] data_sram_addr,
  output logic [31:0]       data_sram_wdata,
  input  logic              data_sram_addr_ok,
  input  logic              data_sram_data_ok,
  input  logic [31:0]       data_sram_rdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_data,
  output logic              rsp_is_store,
  output logic [CNT_W-1:0]  outst_cnt,
  output logic              err_spurious
);

  mem_op_e    op;
  logic       ale;
  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  logic       live_pop;
  trk_entry_t head;
  logic [31:0] shifted;
  logic [31:0] ext_data;

  assign op = mem_op_e'(in_op);

`ifdef LSU_ALE_CHECK_EN
  assign ale = in_valid &
               ((((op == LD_W) || (op == ST_W)) && (in_addr[1:0] != 2'b00)) ||
                (((op == LD_H) || (op == LD_HU) || (op == ST_H)) && in_addr[0]));
  assign ale_exc = ale & ~flush & ~reset;
`else
  assign ale     = 1'b0;
  assign ale_exc = 1'b0;
`endif

  assign full          = (outst_cnt == CNT_W'(MAX_OUTST));
  assign data_sram_req = in_valid & ~ale & ~flush & ~full & ~reset;
  assign in_ready      = (data_sram_req & data_sram_addr_ok) | ale_exc;
  assign data_sram_wr   = is_store(op);
  assign data_sram_size = op_size(op);
  assign data_sram_addr = in_addr;

  always_comb begin
    data_sram_wstrb = 4'b0000;
    data_sram_wdata = in_wdata;
    case (op)
      ST_B: begin
        data_sram_wstrb = 4'b0001 << in_addr[1:0];
        data_sram_wdata = {4{in_wdata[7:0]}};
      end
      ST_H: begin
        data_sram_wstrb = in_addr[1] ? 4'b1100 : 4'b0011;
        data_sram_wdata = {2{in_wdata[15:0]}};
      end
      ST_W: data_sram_wstrb = 4'b1111;
      default: ;
    endcase
  end

  assign push = data_sram_req & data_sram_addr_ok;
  assign pop  = data_sram_data_ok & ~empty;
  // flush in the pop cycle kills the entry being popped, not only the survivors
  assign live_pop = pop & ~head.kill & ~flush;

  lsu_outst_fifo #(.DEPTH(MAX_OUTST)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({op, in_addr[1:0], 1'b0}),
    .pop       (pop),
    .kill_all  (flush),
    .head      (head),
    .cnt       (outst_cnt),
    .empty     (empty)
  );

  assign shifted = data_sram_rdata >> {head.lo2, 3'b000};

  always_comb begin
    ext_data = 32'h0;
    case (head.op)
      LD_B:    ext_data = {{24{shifted[7]}}, shifted[7:0]};
      LD_BU:   ext_data = {24'h0, shifted[7:0]};
      LD_H:    ext_data = {{16{shifted[15]}}, shifted[15:0]};
      LD_HU:   ext_data = {16'h0, shifted[15:0]};
      LD_W:    ext_data = data_sram_rdata;
      default: ext_data = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid    <= 1'b0;
      rsp_data     <= 32'h0;
      rsp_is_store <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      rsp_valid <= live_pop;
      if (live_pop) begin
        rsp_data     <= ext_data;
        rsp_is_store <= is_store(head.op);
      end
      if (data_sram_data_ok & empty) err_spurious <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lsu_req_tracker.sv
// Directed self-checking bench for lsu_req_tracker (MAX_OUTST=2).
module tb_lsu_req_tracker;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic        ale_exc;
  logic        flush;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_is_store;
  logic [1:0]  outst_cnt;
  logic        err_spurious;

  int checks = 0;
  int errors = 0;

  lsu_req_tracker #(.ADDR_W(32), .MAX_OUTST(2)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_op             (in_op),
    .in_addr           (in_addr),
    .in_wdata          (in_wdata),
    .ale_exc           (ale_exc),
    .flush             (flush),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_size    (data_sram_size),
    .data_sram_wstrb   (data_sram_wstrb),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wdata   (data_sram_wdata),
    .data_sram_addr_ok (data_sram_addr_ok),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .rsp_valid         (rsp_valid),
    .rsp_data          (rsp_data),
    .rsp_is_store      (rsp_is_store),
    .outst_cnt         (outst_cnt),
    .err_spurious      (err_spurious)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input mem_op_e op, input logic [31:0] addr, input logic [31:0] wd);
    in_valid = 1'b1;
    in_op    = op;
    in_addr  = addr;
    in_wdata = wd;
    #1;
  endtask

  task automatic respond(input logic [31:0] rd);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = rd;
    step();
    data_sram_data_ok = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_op = 3'd0; in_addr = '0; in_wdata = '0;
    flush = 1'b0; data_sram_addr_ok = 1'b1; data_sram_data_ok = 1'b0; data_sram_rdata = '0;
    step(); step();
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_cnt", outst_cnt, 0);
    chk("rst_err", err_spurious, 0);
    chk("rst_req", data_sram_req, 0);
    reset = 1'b0;
    #1;

    // LD_B sign-extend from byte 3
    drive(LD_B, 32'h1003, 32'h0);
    chk("ldb_req", data_sram_req, 1);
    chk("ldb_size", data_sram_size, 0);
    chk("ldb_wstrb", data_sram_wstrb, 4'b0000);
    chk("ldb_wr", data_sram_wr, 0);
    chk("ldb_ready", in_ready, 1);
    step(); in_valid = 1'b0; #1;
    chk("ldb_cnt", outst_cnt, 1);
    chk("ldb_no_rsp_yet", rsp_valid, 0);
    respond(32'h80FF_FF12);
    chk("ldb_rsp_valid", rsp_valid, 1);
    chk("ldb_rsp_data", rsp_data, 32'hFFFF_FF80);
    chk("ldb_rsp_st", rsp_is_store, 0);
    chk("ldb_cnt0", outst_cnt, 0);
    step();
    chk("ldb_rsp_pulse", rsp_valid, 0);

    // ST_H upper half
    drive(ST_H, 32'h2002, 32'h1234_ABCD);
    chk("sth_wstrb", data_sram_wstrb, 4'b1100);
    chk("sth_wdata", data_sram_wdata, 32'hABCD_ABCD);
    chk("sth_wr", data_sram_wr, 1);
    chk("sth_size", data_sram_size, 1);
    step(); in_valid = 1'b0; #1;
    respond(32'hDEAD_BEEF);
    chk("sth_rsp_valid", rsp_valid, 1);
    chk("sth_rsp_st", rsp_is_store, 1);
    chk("sth_rsp_data", rsp_data, 0);

    // ST_B byte 1
    drive(ST_B, 32'h5001, 32'h0000_00A5);
    chk("stb_wstrb", data_sram_wstrb, 4'b0010);
    chk("stb_wdata", data_sram_wdata, 32'hA5A5_A5A5);
    step(); in_valid = 1'b0; #1;
    respond(32'h0);

    // LD_H / LD_HU on upper half
    drive(LD_H, 32'h4002, 32'h0);
    step(); in_valid = 1'b0; #1;
    respond(32'h8001_7FFF);
    chk("ldh_rsp_data", rsp_data, 32'hFFFF_8001);
    drive(LD_HU, 32'h4002, 32'h0);
    step(); in_valid = 1'b0; #1;
    respond(32'h8001_7FFF);
    chk("ldhu_rsp_data", rsp_data, 32'h0000_8001);

    // misaligned word
    drive(LD_W, 32'h3001, 32'h0);
`ifdef LSU_ALE_CHECK_EN
    chk("ale_req", data_sram_req, 0);
    chk("ale_ready", in_ready, 1);
    chk("ale_exc", ale_exc, 1);
    step(); in_valid = 1'b0; #1;
    chk("ale_cnt", outst_cnt, 0);
`else
    chk("noale_req", data_sram_req, 1);
    chk("noale_addr", data_sram_addr, 32'h3001);
    chk("noale_exc", ale_exc, 0);
    step(); in_valid = 1'b0; #1;
    chk("noale_cnt", outst_cnt, 1);
    respond(32'h1122_3344);
    chk("noale_rsp", rsp_data, 32'h1122_3344);
`endif

    // three back-to-back words against a depth of two
    drive(LD_W, 32'h100, 32'h0);
    chk("b2b_req0", data_sram_req, 1);
    step();
    drive(LD_W, 32'h104, 32'h0);
    chk("b2b_req1", data_sram_req, 1);
    chk("b2b_cnt1", outst_cnt, 1);
    step();
    drive(LD_W, 32'h108, 32'h0);
    chk("b2b_full_req", data_sram_req, 0);
    chk("b2b_full_ready", in_ready, 0);
    chk("b2b_cnt2", outst_cnt, 2);
    step();
    chk("b2b_held_req", data_sram_req, 0);
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hAAAA_0001; #1;
    chk("b2b_pop_cycle_req", data_sram_req, 0);
    step(); data_sram_data_ok = 1'b0; #1;
    chk("b2b_rsp0_valid", rsp_valid, 1);
    chk("b2b_rsp0_data", rsp_data, 32'hAAAA_0001);
    chk("b2b_cnt_after_pop", outst_cnt, 1);
    chk("b2b_req2", data_sram_req, 1);
    step(); in_valid = 1'b0; #1;
    chk("b2b_cnt_refill", outst_cnt, 2);
    respond(32'hBBBB_0002);
    chk("b2b_rsp1_data", rsp_data, 32'hBBBB_0002);
    respond(32'hCCCC_0003);
    chk("b2b_rsp2_data", rsp_data, 32'hCCCC_0003);
    chk("b2b_cnt_end", outst_cnt, 0);

    // flush with two in flight; first pop lands in the flush cycle
    drive(LD_W, 32'h200, 32'h0); step();
    drive(LD_W, 32'h204, 32'h0); step();
    in_valid = 1'b0;
    flush = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1111_1111;
    step();
    flush = 1'b0; data_sram_data_ok = 1'b0; #1;
    chk("fl_pop_rsp", rsp_valid, 0);
    chk("fl_cnt1", outst_cnt, 1);
    respond(32'h2222_2222);
    chk("fl_killed_rsp", rsp_valid, 0);
    chk("fl_cnt0", outst_cnt, 0);
    flush = 1'b1;
    drive(LD_W, 32'h300, 32'h0);
    chk("fl_req_blocked", data_sram_req, 0);
    chk("fl_ready_blocked", in_ready, 0);
    step();
    flush = 1'b0; #1;
    chk("fl_new_req", data_sram_req, 1);
    step(); in_valid = 1'b0; #1;
    respond(32'h0000_0055);
    chk("fl_new_rsp_valid", rsp_valid, 1);
    chk("fl_new_rsp_data", rsp_data, 32'h0000_0055);

    // reset mid-transfer, then spurious data_ok
    drive(LD_W, 32'h400, 32'h0); step(); in_valid = 1'b0;
    reset = 1'b1; step(); reset = 1'b0; #1;
    chk("midrst_cnt", outst_cnt, 0);
    respond(32'h9999_9999);
    chk("spur_err", err_spurious, 1);
    chk("spur_rsp", rsp_valid, 0);
    chk("spur_cnt", outst_cnt, 0);
    step();
    chk("spur_sticky", err_spurious, 1);
    reset = 1'b1; step(); reset = 1'b0; #1;
    chk("spur_clr", err_spurious, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
